wbit_byte_memory: RTL and testbench

//  Parametrised byte-addressed, little-endian 32-bit word memory for the single-cycle ARM core.

---
 rtl/wbit_mem_pkg.sv | 23 ++
 rtl/wbit_mem_rsp_pipe.sv | 32 +++
 rtl/wbit_byte_memory.sv | 126 ++++++++++++
 tb/tb_wbit_byte_memory.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wbit_mem_pkg.sv
// Shared definitions for the byte-addressed word memory: FSM states,
// lane geometry and the response record carried down the latency pipe.
package wbit_mem_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WORD_W     = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic              valid;
    logic              fault;
    logic [WORD_W-1:0] rdata;
  } mem_rsp_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/wbit_mem_rsp_pipe.sv
// Fixed-depth shift register that delays a response record by LAT cycles.
// Reset empties every stage so nothing in flight survives a reset.
module wbit_mem_rsp_pipe
  import wbit_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  mem_rsp_t rsp_i,
  output mem_rsp_t rsp_o
);

  mem_rsp_t stage_q [LAT];

  // Shift one stage per cycle; stage 0 captures the response formed at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[LAT-1];

endmodule

// File: rtl/wbit_byte_memory.sv
// Byte-addressed little-endian 32-bit word memory with per-byte strobes,
// misalignment faults, configurable read latency and optional post-reset clear.
module wbit_byte_memory
  import wbit_mem_pkg::*;
#(
  parameter int DEPTH_BYTES    = 64,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_busy
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / BYTE_LANES;
  localparam int WAW   = AW - 2;
  localparam logic [WAW-1:0] LAST_WORD = WAW'(WORDS - 1);

  mem_state_e        state_q;
  logic [WAW-1:0]    clr_idx_q;
  logic              accept_s;
  logic              misaligned_s;
  logic              wr_en_s;
  logic              clr_en_s;
  logic [WAW-1:0]    word_idx_s;
  logic [WAW-1:0]    bank_idx_s;
  logic [WORD_W-1:0] rd_word_s;
  mem_rsp_t          rsp_d;
  mem_rsp_t          rsp_q;
  logic              unused_addr_s;

  // Upper address bits alias onto the array
  assign word_idx_s    = req_addr[AW-1:2];
  assign unused_addr_s = ^req_addr[31:AW];
  assign misaligned_s  = is_misaligned(req_addr[1:0]);
  assign clr_en_s      = (state_q == ST_CLEAR);
  assign req_ready     = (state_q == ST_READY) & ~reset;
  assign init_busy     = clr_en_s;
  assign accept_s      = req_valid & req_ready;
  assign wr_en_s       = accept_s & req_we & ~misaligned_s;
  assign bank_idx_s    = clr_en_s ? clr_idx_q : word_idx_s;

  // Clear sequencer: one zero word per cycle, then hand over to requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_WORD) begin
            state_q   <= ST_READY;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + WAW'(1);
          end
        end
        ST_READY: clr_idx_q <= '0;
        default: begin
          state_q   <= ST_READY;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < BYTE_LANES; b++) begin : g_bank
    logic [7:0] mem_q [WORDS];
    logic       lane_we_s;

    assign lane_we_s = clr_en_s | (wr_en_s & req_be[b]);

    // Byte lane write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
      if (lane_we_s) begin
        mem_q[bank_idx_s] <= clr_en_s ? 8'h00 : req_wdata[8*b +: 8];
      end
    end

    assign rd_word_s[8*b +: 8] = mem_q[word_idx_s];
  end

  // Response formed at accept; faults and writes carry zero data
  always_comb begin
    rsp_d = '0;
    if (accept_s) begin
      rsp_d.valid = 1'b1;
      rsp_d.fault = misaligned_s;
      if (!req_we && !misaligned_s) begin
        rsp_d.rdata = rd_word_s;
      end else begin
        rsp_d.rdata = '0;
      end
    end else begin
      rsp_d = '0;
    end
  end

  if (READ_LAT == 0) begin : g_comb
    assign rsp_q = rsp_d;
  end else begin : g_pipe
    wbit_mem_rsp_pipe #(
      .LAT(READ_LAT)
    ) u_rsp_pipe (
      .clk  (clk),
      .reset(reset),
      .rsp_i(rsp_d),
      .rsp_o(rsp_q)
    );
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_fault = rsp_q.fault;
  assign rsp_rdata = rsp_q.rdata;

endmodule

// File: tb/tb_wbit_byte_memory.sv
// Bench for wbit_byte_memory: directed table on a clear-on-reset, latency-1
// instance and randomized pipelined traffic on a latency-3 instance.
module tb_wbit_byte_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_ready, a_we, a_rsp_valid, a_rsp_fault, a_busy;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;

  logic        b_rst, b_valid, b_ready, b_we, b_rsp_valid, b_rsp_fault, b_busy;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;

  wbit_byte_memory #(.DEPTH_BYTES(64), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .clk(clk), .reset(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_be(a_be), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rdata), .rsp_fault(a_rsp_fault), .init_busy(a_busy)
  );

  wbit_byte_memory #(.DEPTH_BYTES(64), .READ_LAT(3), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clk(clk), .reset(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_be(b_be), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata), .rsp_fault(b_rsp_fault), .init_busy(b_busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[14];

  // One directed request on instance A, response expected one cycle later
  task automatic a_apply(input vec_t v);
    a_valid = 1'b1; a_we = v.we; a_be = v.be; a_addr = v.addr; a_wdata = v.wdata;
    @(negedge clk);
    chk("a_req_ready", 32'(a_ready), 32'd1);
    chk("a_idle_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0; a_we = 1'b0;
    @(negedge clk);
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("a_rsp_fault", 32'(a_rsp_fault), 32'(v.fault));
    chk("a_rsp_rdata", a_rdata, v.rdata);
    @(posedge clk); #1;
  endtask

  // Reference model for instance B: plain byte array plus a timed response queue
  logic [7:0] mem_b [64];
  typedef struct {
    int          due;
    logic        fault;
    logic [31:0] rdata;
  } exp_t;
  exp_t q_b[$];
  int   cyc_b = 0;

  task automatic b_cycle(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   a;
    logic hit;
    logic rdy;
    b_valid = v; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
    @(negedge clk);
    hit = (q_b.size() > 0) && (q_b[0].due == cyc_b);
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(hit));
    if (hit) begin
      e = q_b.pop_front();
      chk("b_rsp_fault", 32'(b_rsp_fault), 32'(e.fault));
      chk("b_rsp_rdata", b_rdata, e.rdata);
    end
    rdy = b_ready;
    if (v) chk("b_req_ready", 32'(rdy), 32'd1);
    @(posedge clk);
    if (v && rdy) begin
      a       = int'(addr % 32'd64);
      e.due   = cyc_b + 3;
      e.fault = (a % 4) != 0;
      e.rdata = 32'h0;
      if (!e.fault) begin
        if (we) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_b[a+i] = wdata[8*i +: 8];
          end
        end else begin
          e.rdata = {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
        end
      end
      q_b.push_back(e);
    end
    cyc_b++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n_busy;
    logic [31:0] ad;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1122_3344};
    tbl[2]  = '{1'b1, 4'h5, 32'h0000_0008, 32'hAABB_CCDD, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 4'h0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h00BB_00DD};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 4'hF, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 4'h0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[7]  = '{1'b0, 4'h0, 32'h0000_003C, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b1, 4'h8, 32'h0000_0040, 32'h5566_7788, 1'b0, 32'h0000_0000};
    tbl[9]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h5522_3344};
    tbl[10] = '{1'b0, 4'h0, 32'hFFFF_FF48, 32'h0000_0000, 1'b0, 32'h00BB_00DD};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_000C, 32'h1234_5678, 1'b0, 32'h0000_0000};
    tbl[12] = '{1'b0, 4'h0, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[13] = '{1'b0, 4'h0, 32'h0000_0007, 32'h0000_0000, 1'b1, 32'h0000_0000};

    a_rst = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 32'h0; a_wdata = 32'h0;
    b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("a_reset_rsp_rdata", a_rdata, 32'h0);
    chk("a_reset_rsp_fault", 32'(a_rsp_fault), 32'd0);
    chk("a_reset_init_busy", 32'(a_busy), 32'd1);
    chk("b_reset_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("b_reset_init_busy", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Clear sequence length on instance A, bounded wait
    n_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_busy) break;
      chk("a_ready_during_clear", 32'(a_ready), 32'd0);
      n_busy++;
    end
    chk("a_clear_cycles", n_busy, 32'd16);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) a_apply(tbl[i]);

    // Instance B: give every word a known value, then random pipelined traffic
    for (int w = 0; w < 16; w++) b_cycle(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom);
    for (int i = 0; i < 400; i++) begin
      ad = $urandom;
      if ($urandom_range(3) != 0) ad[1:0] = 2'b00;
      b_cycle(1'($urandom_range(4) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)),
              ad, $urandom);
    end
    repeat (4) b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Back-to-back reads: responses on three consecutive cycles, 3 after accept
    b_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    repeat (5) b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset with two reads in flight: they must never appear
    b_cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    b_valid = 1'b0;
    b_rst = 1'b1;
    q_b.delete();
    @(negedge clk);
    chk("b_rsp_valid_in_reset", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    repeat (6) b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Contents survive reset; 0x40 aliases to word 0
    b_cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h0, 32'h3C, 32'h0);
    repeat (5) b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
